// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM.
// Sequences FETCH/DCD/EXE/MEM/WB for add, addu, subu, ori, lui, lw, sw, beq
// and j; illegal instructions, add overflow and memory-wait timeouts park the
// machine in an absorbing TRAP state that only reset can leave.
module mc_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int TRAP_ON_OVF  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       flow,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       GPRWr,
  output logic       DMWr,
  output logic       mem_req,
  output logic [1:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [2:0] state,
  output logic       trap,
  output logic       retire
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_TRAP  = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  // A zero-width counter is not legal, so MEM_WAIT_MAX=0 keeps one dead bit.
  localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_WAIT_MAX > 0);
  localparam bit OVF_TRAPS  = (TRAP_ON_OVF != 0);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic is_add, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic is_legal, in_wait, wait_timeout, ovf_trap;

  // Instruction decode from the IR fields.
  always_comb begin
    is_add   = (opcode == OP_RTYPE) && (funct == FN_ADD);
    is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    is_ori   = (opcode == OP_ORI);
    is_lui   = (opcode == OP_LUI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    is_legal = is_add | is_addu | is_subu | is_ori | is_lui |
               is_lw | is_sw | is_beq | is_j;
  end

  // Memory-wait bookkeeping: timeout fires on the last permitted waiting cycle.
  always_comb begin
    in_wait      = (state_q == S_FETCH) || (state_q == S_MEM);
    wait_timeout = TIMEOUT_EN && in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
    ovf_trap     = OVF_TRAPS && is_add && flow;
  end

  // State register and saturating wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      if (in_wait && !mem_ready) begin
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state_q)
        S_FETCH: begin
          if (mem_ready)         state_q <= S_DCD;
          else if (wait_timeout) state_q <= S_TRAP;
        end
        S_DCD: begin
          if (is_j)           state_q <= S_FETCH;
          else if (!is_legal) state_q <= S_TRAP;
          else                state_q <= S_EXE;
        end
        S_EXE: begin
          if (is_beq)             state_q <= S_FETCH;
          else if (is_lw | is_sw) state_q <= S_MEM;
          else if (ovf_trap)      state_q <= S_TRAP;
          else                    state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready)         state_q <= is_sw ? S_FETCH : S_WB;
          else if (wait_timeout) state_q <= S_TRAP;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  assign state = state_q;

  // Control outputs from state, decode and inputs; reset masks every enable
  // combinationally so an aborted sw or writeback drops in the same cycle.
  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    GPRWr   = 1'b0;
    DMWr    = 1'b0;
    mem_req = 1'b0;
    ALUOp   = ALU_ADD;
    NPCOp   = NPC_SEQ;
    trap    = 1'b0;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
      end
      S_DCD: begin
        if (is_j) begin
          PCWr   = 1'b1;
          NPCOp  = NPC_JUMP;
          retire = 1'b1;
        end
      end
      S_EXE: begin
        if (is_subu | is_beq) ALUOp = ALU_SUB;
        else if (is_ori)      ALUOp = ALU_OR;
        else if (is_lui)      ALUOp = ALU_LUI;
        else                  ALUOp = ALU_ADD;
        if (is_beq) begin
          PCWr   = zero;
          NPCOp  = NPC_BRANCH;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        DMWr    = is_sw;
        retire  = is_sw && mem_ready;
      end
      S_WB: begin
        GPRWr  = 1'b1;
        retire = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b1;
    endcase

    if (rst) begin
      PCWr   = 1'b0;
      IRWr   = 1'b0;
      GPRWr  = 1'b0;
      DMWr   = 1'b0;
      trap   = 1'b0;
      retire = 1'b0;
    end
  end

endmodule
